stream_demux_n: RTL

Parametrised, registered 1-to-N demultiplexer with valid/ready handshaking. It routes each accepted input beat to exactly one of N_OUT output channels. The channel is chosen by an explicit select field or by an internal round-robin pointer. It replaces ad-hoc combinational 1x4 demuxes wherever traffic crosses a clocked boundary. It also counts beats dropped because of an illegal select.

---
 rtl/stream_demux_n.sv | 102 ++++++++++
 1 files changed

// File: rtl/stream_demux_n.sv
`default_nettype none
// ============================================================================
//  Module   : stream_demux_n
//  Purpose  : Registered 1-to-N valid/ready demultiplexer. Each accepted beat
//             is routed to one output channel, chosen by an explicit select or
//             by an internal round-robin pointer. Beats aimed at a
//             non-existent channel are dropped and counted (saturating).
//  Revision : 1.0  initial release
// ============================================================================
module stream_demux_n #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    mode,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]        rr_ptr,
  output logic                    drop_err,
  output logic [CNT_W-1:0]        drop_cnt
);

  // Select space is a power of two; pad out_ready so that any SEL_W index
  // stays inside the vector even when N_OUT is not a power of two.
  localparam int NPAD = 1 << SEL_W;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              state;
  logic [SEL_W-1:0]    dst;
  logic [DATA_W-1:0]   hold_data;

  logic [NPAD-1:0]     ready_pad;
  logic                drain;
  logic                acc;
  logic                legal;
  logic [SEL_W-1:0]    dest;

  assign ready_pad = NPAD'(out_ready);

  // Held beat leaves this cycle only if its own channel is ready.
  assign drain    = (state == ST_FULL) && ready_pad[dst];
  assign in_ready = rst_n && ((state == ST_EMPTY) || ready_pad[dst]);
  assign acc      = in_valid && in_ready;
  assign dest     = mode ? rr_ptr : in_sel;
  assign legal    = {1'b0, dest} < (SEL_W+1)'(N_OUT);

  // Holding register, round-robin pointer and drop bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      dst       <= '0;
      hold_data <= '0;
      rr_ptr    <= '0;
      drop_err  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      drop_err <= acc && !legal;

      if (acc && legal) begin
        state     <= ST_FULL;
        dst       <= dest;
        hold_data <= in_data;
      end else if (drain) begin
        state     <= ST_EMPTY;
        hold_data <= '0;
      end

      if (acc && !legal && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end

      // Pointer only moves on round-robin beats; explicit beats leave it alone.
      if (acc && mode) begin
        if (rr_ptr == SEL_W'(N_OUT - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= rr_ptr + SEL_W'(1);
        end
      end
    end
  end

  // Lane decode: only the held destination shows valid and data; others are 0.
  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    assign out_valid[k] = (state == ST_FULL) && (dst == SEL_W'(k));
    assign out_data[k*DATA_W +: DATA_W] = out_valid[k] ? hold_data : '0;
  end

endmodule
`default_nettype wire
